// File: rtl/axis_uart_tx.sv
// -----------------------------------------------------------------------------
// axis_uart_tx
//   AXI-Stream byte sink feeding a UART transmitter (8N1 for WIDTH=8).
//   Accepted beats land in a small circular FIFO. A start/data/stop
//   serialiser drains the FIFO one frame at a time, LSB first.
//   A beat tagged with s_axis_last raises frame_done for one cycle once its
//   stop bit has completed.
//
// Parameters
//   WIDTH        data bits per beat and per UART frame
//   DEPTH        FIFO entries (power of two, >= 2)
//   CLKS_PER_BIT clk cycles per UART bit (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   s_axis_data  stream payload
//   s_axis_valid payload valid
//   s_axis_last  payload is the final byte of a message
//   s_axis_ready FIFO has room for a beat
//   tx           UART serial line, idles high (registered)
//   tx_busy      serialiser is sending a frame (registered)
//   frame_done   one-cycle pulse after a last-tagged byte's stop bit
//   fifo_count   number of beats currently held in the FIFO
// -----------------------------------------------------------------------------
module axis_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         s_axis_data,
  input  logic                     s_axis_valid,
  input  logic                     s_axis_last,
  output logic                     s_axis_ready,
  output logic                     tx,
  output logic                     tx_busy,
  output logic                     frame_done,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // A one-cycle bit still needs a 1-bit counter so widths stay legal.
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping; each entry is {last, data}.
  logic [WIDTH:0]       mem_r [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;

  // Serialiser state.
  state_t               state_r;
  logic [BAUD_W-1:0]    baud_r;
  logic [IDX_W-1:0]     bit_idx_r;
  logic [WIDTH-1:0]     shift_r;
  logic                 last_r;
  logic                 tx_r;
  logic                 busy_r;
  logic                 done_r;

  // Combinational helpers.
  logic                 ready_s;
  logic                 push_s;
  logic                 pop_s;
  logic [WIDTH:0]       head_s;
  logic                 baud_done_s;
  logic [WIDTH-1:0]     shift_next_s;

  // Handshake, pop condition and helper decodes from registered state.
  always_comb begin
    ready_s      = 1'b0;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    head_s       = mem_r[rd_ptr_r];
    baud_done_s  = 1'b0;
    shift_next_s = shift_r >> 1;
    if (count_r != CNT_FULL) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
    push_s = s_axis_valid & ready_s;
    // Popping only from IDLE means a beat written into an empty FIFO is
    // seen by the serialiser one edge after it was accepted.
    if ((state_r == ST_IDLE) && (count_r != CNT_ZERO)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (baud_r == BAUD_LAST) begin
      baud_done_s = 1'b1;
    end else begin
      baud_done_s = 1'b0;
    end
  end

  // FIFO storage write port; contents are cleared on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(WIDTH + 1){1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= {s_axis_last, s_axis_data};
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Write and read pointers; DEPTH is a power of two so they wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Occupancy count; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= CNT_ZERO;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Serialiser FSM with registered tx, tx_busy and frame_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      baud_r    <= BAUD_ZERO;
      bit_idx_r <= IDX_ZERO;
      shift_r   <= {WIDTH{1'b0}};
      last_r    <= 1'b0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      // frame_done is a single-cycle pulse unless the STOP exit sets it.
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          baud_r    <= BAUD_ZERO;
          bit_idx_r <= IDX_ZERO;
          if (pop_s) begin
            shift_r <= head_s[WIDTH-1:0];
            last_r  <= head_s[WIDTH];
            state_r <= ST_START;
            busy_r  <= 1'b1;
            tx_r    <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            tx_r    <= 1'b1;
          end
        end

        ST_START: begin
          if (baud_done_s) begin
            state_r   <= ST_DATA;
            baud_r    <= BAUD_ZERO;
            bit_idx_r <= IDX_ZERO;
            tx_r      <= shift_r[0];
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
            tx_r   <= 1'b0;
          end
        end

        ST_DATA: begin
          if (baud_done_s) begin
            baud_r <= BAUD_ZERO;
            if (bit_idx_r == IDX_LAST) begin
              state_r <= ST_STOP;
              tx_r    <= 1'b1;
            end else begin
              // Present the next bit in the same edge that shifts it down.
              bit_idx_r <= bit_idx_r + IDX_W'(1);
              shift_r   <= shift_next_s;
              tx_r      <= shift_next_s[0];
            end
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
          end
        end

        ST_STOP: begin
          if (baud_done_s) begin
            state_r <= ST_IDLE;
            baud_r  <= BAUD_ZERO;
            busy_r  <= 1'b0;
            done_r  <= last_r;
            tx_r    <= 1'b1;
          end else begin
            baud_r <= baud_r + BAUD_W'(1);
            tx_r   <= 1'b1;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          baud_r    <= BAUD_ZERO;
          bit_idx_r <= IDX_ZERO;
          busy_r    <= 1'b0;
          tx_r      <= 1'b1;
        end
      endcase
    end
  end

  // Output mapping.
  assign s_axis_ready = ready_s;
  assign tx           = tx_r;
  assign tx_busy      = busy_r;
  assign frame_done   = done_r;
  assign fifo_count   = count_r;

endmodule

// File: tb/tb_axis_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_axis_uart_tx
//   Self-checking bench for axis_uart_tx. Two instances: CLKS_PER_BIT=4 and
//   CLKS_PER_BIT=1, selected by sel. The reference model records, per
//   accepted beat, its accept edge and derived pop edge, and from those
//   computes the expected line level, busy flag, done pulse and occupancy
//   for any clock edge.
// -----------------------------------------------------------------------------
module tb_axis_uart_tx;

  localparam int W = 8;
  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic       valid;
  logic       last;
  logic [7:0] data;
  bit         sel;

  logic       v4, ready4, tx4, busy4, done4;
  logic [2:0] cnt4;
  logic       v1, ready1, tx1, busy1, done1;
  logic [2:0] cnt1;

  logic       o_tx, o_busy, o_done, o_ready;
  logic [2:0] o_cnt;

  assign v4      = valid & ~sel;
  assign v1      = valid & sel;
  assign o_tx    = sel ? tx1    : tx4;
  assign o_busy  = sel ? busy1  : busy4;
  assign o_done  = sel ? done1  : done4;
  assign o_ready = sel ? ready1 : ready4;
  assign o_cnt   = sel ? cnt1   : cnt4;

  axis_uart_tx #(.WIDTH(W), .DEPTH(D), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .s_axis_data(data), .s_axis_valid(v4),
    .s_axis_last(last), .s_axis_ready(ready4), .tx(tx4), .tx_busy(busy4),
    .frame_done(done4), .fifo_count(cnt4)
  );

  axis_uart_tx #(.WIDTH(W), .DEPTH(D), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .s_axis_data(data), .s_axis_valid(v1),
    .s_axis_last(last), .s_axis_ready(ready1), .tx(tx1), .tx_busy(busy1),
    .frame_done(done1), .fifo_count(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  int         cyc;
  int         mc;
  bit         in_reset;
  int         nf;
  int         f_acc  [64];
  int         f_pop  [64];
  logic [7:0] f_data [64];
  bit         f_last [64];

  int         n_checks;
  int         n_err;
  int         done_seen;
  int         max_cnt;
  bit         ready_low;
  bit         acc_last;
  logic [7:0] q_data [$];
  bit         q_last [$];

  function automatic int frame_len();
    return (W + 2) * mc;
  endfunction

  function automatic int model_count(int e);
    int c;
    c = 0;
    if (!in_reset) begin
      for (int i = 0; i < nf; i++) begin
        if (f_acc[i] <= e) c++;
        if (f_pop[i] <= e) c--;
      end
    end
    return c;
  endfunction

  // Expected outputs just after clock edge e.
  task automatic model_out(input int e, output logic etx, output logic ebusy,
                           output logic edone, output int ecnt);
    int d;
    etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
    ecnt = model_count(e);
    if (!in_reset) begin
      for (int i = 0; i < nf; i++) begin
        d = e - f_pop[i];
        if (d >= 0 && d < frame_len()) begin
          ebusy = 1'b1;
          if (d < mc)                etx = 1'b0;
          else if (d < (W + 1) * mc) etx = f_data[i][(d - mc) / mc];
          else                       etx = 1'b1;
        end
        if (d == frame_len()) edone = f_last[i];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock: record acceptance, advance the edge, compare every output.
  task automatic step();
    logic etx, ebusy, edone;
    int   ecnt;
    bit   acc;
    int   p;
    acc = valid && !in_reset && (model_count(cyc) != D);
    @(posedge clk);
    cyc++;
    if (acc) begin
      p = cyc + 1;
      if (nf > 0 && f_pop[nf-1] + frame_len() + 1 > p) p = f_pop[nf-1] + frame_len() + 1;
      f_acc[nf] = cyc; f_pop[nf] = p; f_data[nf] = data; f_last[nf] = last;
      nf++;
    end
    acc_last = acc;
    #1;
    model_out(cyc, etx, ebusy, edone, ecnt);
    chk("tx", o_tx, etx);
    chk("tx_busy", o_busy, ebusy);
    chk("frame_done", o_done, edone);
    chk("fifo_count", o_cnt, ecnt);
    chk("s_axis_ready", o_ready, (ecnt != D));
    if (o_done === 1'b1) done_seen++;
    if (int'(o_cnt) > max_cnt) max_cnt = int'(o_cnt);
    if (o_ready === 1'b0) ready_low = 1'b1;
  endtask

  task automatic send(input bit gaps);
    int guard;
    guard = 0;
    while (q_data.size() > 0 && guard < 600) begin
      valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      data  = q_data[0];
      last  = q_last[0];
      step();
      if (acc_last) begin
        void'(q_data.pop_front());
        void'(q_last.pop_front());
      end
      guard++;
    end
    valid = 1'b0;
    data  = 8'($urandom);
    last  = 1'($urandom);
    chk("send_complete", q_data.size(), 0);
    q_data.delete();
    q_last.delete();
  endtask

  task automatic drain();
    int target;
    int guard;
    target = (nf > 0) ? f_pop[nf-1] + frame_len() + 2 : cyc + 1;
    guard  = 0;
    while (cyc < target && guard < 2000) begin
      step();
      guard++;
    end
    chk("drain_idle", o_busy, 1'b0);
  endtask

  task automatic add_beat(input logic [7:0] b, input bit l);
    q_data.push_back(b);
    q_last.push_back(l);
  endtask

  initial begin
    int d0;
    int base;
    n_checks = 0; n_err = 0; cyc = 0; nf = 0; mc = 4; sel = 1'b0;
    done_seen = 0; max_cnt = 0; ready_low = 1'b0;
    valid = 1'b0; data = 8'h00; last = 1'b0;

    // Reset held with random inputs.
    rst = 1'b0; in_reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      valid = 1'($urandom); data = 8'($urandom); last = 1'($urandom);
      step();
    end
    valid = 1'b0;
    rst = 1'b1; in_reset = 1'b0;
    step();

    // Single beat 0x48, no last tag.
    d0 = done_seen;
    add_beat(8'h48, 1'b0);
    send(1'b0);
    drain();
    chk("t2_no_done", done_seen - d0, 0);

    // Six beats with valid held: FIFO fills and back-pressures.
    max_cnt = 0; ready_low = 1'b0;
    for (int i = 1; i <= 6; i++) add_beat(8'(i), 1'b0);
    send(1'b0);
    drain();
    chk("t3_count_le_depth", (max_cnt <= D), 1'b1);
    chk("t3_ready_dropped", ready_low, 1'b1);

    // "HELLO\n" with last on the newline.
    d0 = done_seen;
    add_beat(8'h48, 1'b0); add_beat(8'h45, 1'b0); add_beat(8'h4C, 1'b0);
    add_beat(8'h4C, 1'b0); add_beat(8'h4F, 1'b0); add_beat(8'h0A, 1'b1);
    send(1'b0);
    drain();
    chk("t4_done_pulses", done_seen - d0, 1);

    // Random bytes, random last tags, random valid gaps.
    for (int i = 0; i < 10; i++) add_beat(8'($urandom), 1'($urandom));
    send(1'b1);
    drain();

    // Asynchronous reset in the middle of 0xA5's data bits.
    base = nf;
    add_beat(8'hA5, 1'b0); add_beat(8'h11, 1'b1);
    send(1'b0);
    while (cyc < f_pop[base] + 2 * mc + 1) step();
    #3;
    rst = 1'b0; in_reset = 1'b1; nf = 0;
    #1;
    chk("t5_async_tx", o_tx, 1'b1);
    chk("t5_async_count", o_cnt, 3'd0);
    chk("t5_async_busy", o_busy, 1'b0);
    chk("t5_async_ready", o_ready, 1'b1);
    step(); step();
    rst = 1'b1; in_reset = 1'b0;
    d0 = done_seen;
    add_beat(8'h3C, 1'b0);
    send(1'b0);
    drain();
    chk("t5_no_done", done_seen - d0, 0);

    // One clock per bit: 0xFF then 0x00 back to back.
    sel = 1'b1; mc = 1; nf = 0;
    step();
    add_beat(8'hFF, 1'b0); add_beat(8'h00, 1'b1);
    d0 = done_seen;
    send(1'b0);
    drain();
    chk("t6_done_pulses", done_seen - d0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
